// File: rtl/word_narrow_32t16_pkg.sv
// Shared datapath definitions for the 32->16 narrowing converter:
// FSM state encoding and word/halfword widths.
package word_narrow_32t16_pkg;

   localparam int HALF_W = 16;
   localparam int WORD_W = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_EMPTY = 2'd0;
   localparam state_t ST_LO    = 2'd1;
   localparam state_t ST_HI    = 2'd2;

endpackage

// File: rtl/word_narrow_32t16.sv
// Narrows 32-bit words to 16-bit halfwords (SPLIT: low then high, TRUNC: low only).
// Optional feature macro ZERO_HI_SKIP_EN: SPLIT words with a zero upper half emit one beat.
module word_narrow_32t16
   import word_narrow_32t16_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_split,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [HALF_W-1:0] out_data,
   output logic              out_hi,
   output logic              out_last,
   output logic              out_trunc_loss,
   output logic [CNT_W-1:0]  words_done
);

   state_t            state_q;
   state_t            state_d;
   logic [WORD_W-1:0] buf_q;
   logic              split_q;
   logic              split_eff;
   logic              in_xfer;
   logic              out_xfer;

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   // A SPLIT word whose upper half is zero is stored as a single-beat word.
`ifdef ZERO_HI_SKIP_EN
   assign split_eff = in_split & (in_data[WORD_W-1:HALF_W] != '0);
`else
   assign split_eff = in_split;
`endif

   // Accept a new word when idle, or in the same cycle the final beat leaves.
   assign in_ready = rst_n & ((state_q == ST_EMPTY) | (out_xfer & out_last));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         split_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (in_xfer) begin
            split_q <= split_eff;
         end
      end
   end

   // NOTE: the data buffer needs no reset; every output derived from it is gated by state.
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         buf_q <= in_data;
      end
   end

   // NOTE: default assignment first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_EMPTY: begin
            if (in_xfer) state_d = ST_LO;
         end
         ST_LO: begin
            if (out_xfer) begin
               if (split_q)      state_d = ST_HI;
               else if (in_xfer) state_d = ST_LO;
               else              state_d = ST_EMPTY;
            end
         end
         ST_HI: begin
            if (out_xfer) state_d = in_xfer ? ST_LO : ST_EMPTY;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_comb begin
      out_valid      = 1'b0;
      out_data       = '0;
      out_hi         = 1'b0;
      out_last       = 1'b0;
      out_trunc_loss = 1'b0;
      unique case (state_q)
         ST_LO: begin
            out_valid      = 1'b1;
            out_data       = buf_q[HALF_W-1:0];
            out_last       = ~split_q;
            out_trunc_loss = ~split_q & (buf_q[WORD_W-1:HALF_W] != '0);
         end
         ST_HI: begin
            out_valid = 1'b1;
            out_data  = buf_q[WORD_W-1:HALF_W];
            out_hi    = 1'b1;
            out_last  = 1'b1;
         end
         default: ;
      endcase
   end

   // Completed-word counter, wraps naturally at 2**CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         words_done <= '0;
      end else if (out_xfer & out_last) begin
         words_done <= words_done + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_word_narrow_32t16.sv
// Self-checking bench for word_narrow_32t16: directed cases plus randomized traffic
// checked against a queue-of-expected-beats model. Honours ZERO_HI_SKIP_EN when defined.
module tb_word_narrow_32t16;

   localparam int CNT_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_data = '0;
   logic              in_split = 1'b0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [15:0]       out_data;
   logic              out_hi;
   logic              out_last;
   logic              out_trunc_loss;
   logic [CNT_W-1:0]  words_done;

   typedef struct {
      logic [15:0] data;
      bit          hi;
      bit          last;
      bit          loss;
   } beat_t;

   beat_t            exp_q[$];
   logic [CNT_W-1:0] model_done = '0;
   int               beats = 0;
   int               errors = 0;
   int               checks = 0;
   bit               rand_ready = 1'b0;
   logic             fixed_ready = 1'b0;

   word_narrow_32t16 #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_data        (in_data),
      .in_split       (in_split),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .out_hi         (out_hi),
      .out_last       (out_last),
      .out_trunc_loss (out_trunc_loss),
      .words_done     (words_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Expected beats of one accepted word, straight from the narrowing rules.
   task automatic push_word(input logic [31:0] d, input logic s);
      bit two_beats;
      two_beats = s;
`ifdef ZERO_HI_SKIP_EN
      if (d[31:16] == 16'h0) two_beats = 1'b0;
`endif
      if (two_beats) begin
         exp_q.push_back('{data: d[15:0],  hi: 1'b0, last: 1'b0, loss: 1'b0});
         exp_q.push_back('{data: d[31:16], hi: 1'b1, last: 1'b1, loss: 1'b0});
      end else begin
         exp_q.push_back('{data: d[15:0], hi: 1'b0, last: 1'b1, loss: (!s && d[31:16] != 16'h0)});
      end
   endtask

   // Consumer ready: either held by the directed sequence or randomized per cycle.
   always @(posedge clk) begin
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : fixed_ready;
   end

   // Monitor: compares every cycle against the model, then advances the model.
   always @(negedge clk) begin
      if (rst_n) begin
         check("out_valid", out_valid, exp_q.size() != 0);
         check("words_done", words_done, model_done);
         if (exp_q.size() != 0) begin
            check("out_data", out_data, exp_q[0].data);
            check("out_hi", out_hi, exp_q[0].hi);
            check("out_last", out_last, exp_q[0].last);
            check("out_trunc_loss", out_trunc_loss, exp_q[0].loss);
            check("in_ready", in_ready, out_ready && exp_q[0].last);
         end else begin
            check("in_ready_idle", in_ready, 1'b1);
         end
         if (out_valid && out_ready && exp_q.size() != 0) begin
            if (exp_q[0].last) model_done = model_done + 1'b1;
            beats++;
            void'(exp_q.pop_front());
         end
         if (in_valid && in_ready) push_word(in_data, in_split);
      end
   end

   task automatic send(input logic [31:0] d, input logic s);
      int  n;
      bit  got;
      n = 0;
      got = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_split = s;
      while (!got && n < 2000) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!got) check("send_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 1000) check("drain_timeout", 32'd0, 32'd1);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   initial begin
      int b0;
      logic [31:0] d;

      // Reset values while held in reset
      #12;
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_words_done", words_done, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      fixed_ready = 1'b1;
      gap(1);

      // SPLIT DEAD_BEEF with consumer always ready
      send(32'hDEAD_BEEF, 1'b1);
      drain();
      check("split_words_done", words_done, 1);

      // Back-to-back TRUNC words, first one loses a non-zero upper half
      send(32'h1234_5678, 1'b0);
      send(32'h0000_9ABC, 1'b0);
      drain();

      // Backpressure: 5 stalled cycles in LO, 3 in HI
      fixed_ready = 1'b0;
      b0 = beats;
      send(32'hCAFE_F00D, 1'b1);
      repeat (5) begin
         @(negedge clk);
         check("bp_lo_in_ready", in_ready, 1'b0);
         check("bp_lo_data", out_data, 16'hF00D);
         @(posedge clk);
         #1;
      end
      fixed_ready = 1'b1;
      @(posedge clk);
      #1;
      fixed_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("bp_hi_in_ready", in_ready, 1'b0);
         check("bp_hi_data", out_data, 16'hCAFE);
         @(posedge clk);
         #1;
      end
      fixed_ready = 1'b1;
      drain();
      check("bp_beats", beats - b0, 2);

      // Asynchronous reset in the middle of a SPLIT word
      fixed_ready = 1'b0;
      send(32'h1111_2222, 1'b1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      model_done = '0;
      beats = 0;
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      check("mid_rst_out_data", out_data, 16'h0);
      check("mid_rst_out_hi", out_hi, 1'b0);
      check("mid_rst_out_last", out_last, 1'b0);
      check("mid_rst_trunc_loss", out_trunc_loss, 1'b0);
      check("mid_rst_words_done", words_done, 0);
      check("mid_rst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", in_ready, 1'b1);
      fixed_ready = 1'b1;
      @(posedge clk);
      #1;

      // Counter wrap with CNT_W=4
      for (int i = 0; i < 17; i++) send($urandom, 1'b0);
      drain();
      check("wrap_trunc_words", words_done, 1);
      b0 = beats;
      for (int i = 0; i < 17; i++) begin
         d = $urandom | 32'h0001_0000;
         send(d, 1'b1);
      end
      drain();
      check("wrap_split_beats", beats - b0, 34);
      check("wrap_split_words", words_done, 2);

      // SPLIT word with zero upper half
      b0 = beats;
      send(32'h0000_00AA, 1'b1);
      drain();
`ifdef ZERO_HI_SKIP_EN
      check("zero_hi_beats", beats - b0, 1);
`else
      check("zero_hi_beats", beats - b0, 2);
`endif

      // Randomized traffic with random consumer stalls and mixed modes
      rand_ready = 1'b1;
      for (int i = 0; i < 300; i++) begin
         d = $urandom;
         if ($urandom_range(0, 3) == 0) d[31:16] = 16'h0;
         send(d, $urandom_range(0, 1) == 1);
         if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
      end
      rand_ready = 1'b0;
      fixed_ready = 1'b1;
      gap(1);
      drain();
      check("final_words_done", words_done, model_done);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
